// File: rtl/ccip_tx_flow_scheduler.sv
// CCI-P TX flow scheduler: round-robin choice of the next flow FIFO to drain.
// A flow competes once it holds a full batch, or a partial batch that has
// waited at least flush_timeout cycles. A grant is held until accepted, then
// the chosen flow is popped for exactly grant_count consecutive cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | scheduling disabled, waiting for start
// ARB   | evaluate eligibility and almost-full, pick the next flow
// GRANT | grant presented, waiting for grant_ready
// POP   | pop strobes for the granted flow, one entry per cycle
// HOLD  | one idle cycle so FIFO occupancy reflects the pops
module ccip_tx_flow_scheduler #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFIFO_DEPTH       = 3,
  parameter int LMAX_CCIP_BATCH   = 2,
  parameter int TIMEOUT_W         = 16
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                        number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]                          l_tx_batch_size,
  input  logic [TIMEOUT_W-1:0]                                flush_timeout,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*(LFIFO_DEPTH+1)-1:0]   ff_occ,
  input  logic                                                tx_almost_full,
  output logic                                                grant_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                        grant_flow,
  output logic [LMAX_CCIP_BATCH:0]                            grant_count,
  output logic                                                grant_flush,
  input  logic                                                grant_ready,
  output logic [(2**LMAX_NUM_OF_FLOWS)-1:0]                   pop_en,
  output logic                                                busy,
  output logic [31:0]                                         stat_flush_cnt
);

  localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int OW        = LFIFO_DEPTH + 1;
  localparam int CW        = LMAX_CCIP_BATCH + 1;
  localparam int FW        = LMAX_NUM_OF_FLOWS;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] GRANT = 3'd2;
  localparam logic [2:0] POP   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]           state;
  logic [FW-1:0]        rr_ptr;
  logic [CW-1:0]        pop_cnt;
  logic [CW-1:0]        batch;
  logic [OW-1:0]        occ      [MAX_FLOWS];
  logic [TIMEOUT_W-1:0] age_q    [MAX_FLOWS];
  logic [MAX_FLOWS-1:0] active;
  logic [MAX_FLOWS-1:0] full_v;
  logic [MAX_FLOWS-1:0] elig;
  logic [FW-1:0]        scan_idx;
  logic                 pick_found;
  logic [FW-1:0]        pick_flow;
  logic                 pick_full;
  logic [CW-1:0]        pick_count;
  logic                 pop_last;

  // Unpack occupancies and mark flows inside the configured range.
  always_comb begin
    for (int f = 0; f < MAX_FLOWS; f++) begin
      occ[f]    = ff_occ[f*OW +: OW];
      active[f] = (f <= int'(number_of_flows));
    end
  end

  // Batch size is a power of two, clamped at the largest supported batch.
  always_comb begin
    if (int'(l_tx_batch_size) >= LMAX_CCIP_BATCH)
      batch = CW'(1) << LMAX_CCIP_BATCH;
    else
      batch = CW'(1) << l_tx_batch_size;
  end

  // Per-flow eligibility: full batch, or an aged partial batch when flushing is enabled.
  always_comb begin
    for (int f = 0; f < MAX_FLOWS; f++) begin
      full_v[f] = int'(occ[f]) >= int'(batch);
      elig[f]   = active[f] &&
                  (full_v[f] ||
                   ((occ[f] != '0) && (flush_timeout != '0) && (age_q[f] >= flush_timeout)));
    end
  end

  // Round-robin scan starting just after the last served flow; anything past
  // number_of_flows wraps to flow 0, which also covers a shrunken flow count.
  always_comb begin
    pick_found = 1'b0;
    pick_flow  = '0;
    scan_idx   = rr_ptr;
    for (int i = 0; i < MAX_FLOWS; i++) begin
      scan_idx = (scan_idx >= number_of_flows) ? '0 : scan_idx + FW'(1);
      if (!pick_found && elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_flow  = scan_idx;
      end
    end
  end

  // Grant size for the picked flow: a full batch, or whatever a partial batch holds.
  always_comb begin
    pick_full  = full_v[pick_flow];
    pick_count = pick_full ? batch : CW'(occ[pick_flow]);
  end

  assign pop_last = (pop_cnt == grant_count - CW'(1));

  // Age counters: cleared when empty, out of range, or just drained; else saturate upward.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < MAX_FLOWS; f++) age_q[f] <= '0;
    end else begin
      for (int f = 0; f < MAX_FLOWS; f++) begin
        if (!active[f] || (occ[f] == '0) ||
            ((state == POP) && pop_last && (int'(grant_flow) == f)))
          age_q[f] <= '0;
        else if (age_q[f] != {TIMEOUT_W{1'b1}})
          age_q[f] <= age_q[f] + TIMEOUT_W'(1);
      end
    end
  end

  // Scheduler FSM; the grant fields are captured in ARB so an in-flight batch
  // is unaffected by later configuration or occupancy changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      pop_cnt        <= '0;
      grant_flow     <= '0;
      grant_count    <= '0;
      grant_flush    <= 1'b0;
      stat_flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= ARB;
        end
        ARB: begin
          if (!start) begin
            state <= IDLE;
          end else if (pick_found && !tx_almost_full) begin
            grant_flow  <= pick_flow;
            grant_count <= pick_count;
            grant_flush <= !pick_full;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            pop_cnt <= '0;
            state   <= POP;
          end
        end
        POP: begin
          if (pop_last) begin
            rr_ptr <= grant_flow;
            if (grant_flush) stat_flush_cnt <= stat_flush_cnt + 32'd1;
            state <= HOLD;
          end else begin
            pop_cnt <= pop_cnt + CW'(1);
          end
        end
        HOLD: begin
          state <= start ? ARB : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decode outputs from the current state.
  always_comb begin
    pop_en = '0;
    if (state == POP) pop_en[grant_flow] = 1'b1;
    grant_valid = (state == GRANT);
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Bench for ccip_tx_flow_scheduler with four flows. A transaction-level model
// tracks flow ages, the round-robin pointer and the flush count from the
// scheduling rules, emulates the flow FIFOs draining on pop_en, and checks
// every grant, every pop strobe and the statistics counter each cycle.
module tb_ccip_tx_flow_scheduler;

  localparam int LNF = 2;
  localparam int LFD = 3;
  localparam int LB  = 2;
  localparam int TW  = 16;
  localparam int NF  = 4;
  localparam int OW  = LFD + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [LNF-1:0]  number_of_flows;
  logic [LB-1:0]   l_tx_batch_size;
  logic [TW-1:0]   flush_timeout;
  logic [NF*OW-1:0] ff_occ;
  logic            tx_almost_full;
  logic            grant_valid;
  logic [LNF-1:0]  grant_flow;
  logic [LB:0]     grant_count;
  logic            grant_flush;
  logic            grant_ready;
  logic [NF-1:0]   pop_en;
  logic            busy;
  logic [31:0]     stat_flush_cnt;

  ccip_tx_flow_scheduler #(
    .LMAX_NUM_OF_FLOWS(LNF),
    .LFIFO_DEPTH(LFD),
    .LMAX_CCIP_BATCH(LB),
    .TIMEOUT_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .number_of_flows(number_of_flows),
    .l_tx_batch_size(l_tx_batch_size),
    .flush_timeout(flush_timeout),
    .ff_occ(ff_occ),
    .tx_almost_full(tx_almost_full),
    .grant_valid(grant_valid),
    .grant_flow(grant_flow),
    .grant_count(grant_count),
    .grant_flush(grant_flush),
    .grant_ready(grant_ready),
    .pop_en(pop_en),
    .busy(busy),
    .stat_flush_cnt(stat_flush_cnt)
  );

  always #5 clk = ~clk;

  int occ [NF];
  int m_age [NF];
  int m_rr, m_stat;
  int pops_left, cur_flow, cur_count;
  bit cur_flush;
  bit pv_prev, pfl_prev, gv_prev;
  int pf_prev, pc_prev;
  int n_cmp, n_err, cyc, run;
  bit chk_en, rand_push;
  logic          s_gv;
  logic [NF-1:0] s_pe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_occ();
    for (int f = 0; f < NF; f++) ff_occ[f*OW +: OW] = OW'(occ[f]);
  endtask

  // What ARB would choose given the current inputs and modelled ages.
  function automatic void model_pick(output bit v, output int pf, output int pc, output bit pfl);
    int nf, lb, b, first, cand;
    bit full, fls;
    nf = int'(number_of_flows);
    lb = (int'(l_tx_batch_size) > 2) ? 2 : int'(l_tx_batch_size);
    b  = 1 << lb;
    first = (m_rr + 1 > nf) ? 0 : m_rr + 1;
    v = 0; pf = 0; pc = 0; pfl = 0;
    for (int k = 0; k <= nf; k++) begin
      cand = (first + k) % (nf + 1);
      full = occ[cand] >= b;
      fls  = (occ[cand] > 0) && (occ[cand] < b) && (flush_timeout != 0) &&
             (m_age[cand] >= int'(flush_timeout));
      if (!v && (full || fls)) begin
        v = 1; pf = cand; pc = full ? b : occ[cand]; pfl = !full;
      end
    end
    if (!start || tx_almost_full) v = 0;
  endfunction

  task automatic tick();
    bit pv, pfl, last, rst_now;
    int pf, pc, nf;
    int nx [NF];
    @(negedge clk);
    s_gv = grant_valid;
    s_pe = pop_en;
    model_pick(pv, pf, pc, pfl);
    if (chk_en) begin
      if (s_gv === 1'b1 && !gv_prev) begin
        check("grant_from_arb", 32'(pv_prev), 1);
        check("grant_flow", 32'(grant_flow), pf_prev);
        check("grant_count", 32'(grant_count), pc_prev);
        check("grant_flush", 32'(grant_flush), 32'(pfl_prev));
        cur_flow = pf_prev; cur_count = pc_prev; cur_flush = pfl_prev;
      end else if (s_gv === 1'b1) begin
        check("grant_hold_flow", 32'(grant_flow), cur_flow);
        check("grant_hold_count", 32'(grant_count), cur_count);
      end
      if (pops_left > 0) check("pop_en", 32'(s_pe), 1 << cur_flow);
      else check("pop_idle", 32'(s_pe), 0);
      check("stat_flush_cnt", stat_flush_cnt, m_stat);
      if (!start || reset) run = 0;
      else if (pv && s_gv !== 1'b1 && pops_left == 0) run++;
      else run = 0;
      check("stall", 32'(run <= 3), 1);
    end
    last = chk_en && (pops_left == 1);
    nf = int'(number_of_flows);
    for (int f = 0; f < NF; f++) begin
      if (f > nf || occ[f] == 0 || (last && f == cur_flow)) nx[f] = 0;
      else nx[f] = (m_age[f] < 65535) ? m_age[f] + 1 : 65535;
    end
    if (pops_left > 0) pops_left--;
    if (last) begin
      m_rr = cur_flow;
      if (cur_flush) m_stat++;
    end
    if (chk_en && s_gv === 1'b1 && grant_ready) pops_left = cur_count;
    pv_prev = pv; pf_prev = pf; pc_prev = pc; pfl_prev = pfl;
    gv_prev = (s_gv === 1'b1);
    rst_now = reset;
    @(posedge clk);
    #1;
    if (rst_now) begin
      for (int f = 0; f < NF; f++) m_age[f] = 0;
      m_rr = 0; m_stat = 0; pops_left = 0; gv_prev = 0; run = 0;
    end else begin
      for (int f = 0; f < NF; f++) m_age[f] = nx[f];
    end
    for (int f = 0; f < NF; f++) begin
      if (s_pe[f] === 1'b1 && occ[f] > 0) occ[f]--;
      if (rand_push && occ[f] < 15 && $urandom_range(0, 3) == 0) occ[f]++;
    end
    drive_occ();
    cyc++;
  endtask

  initial begin
    int first_cyc, second_cyc, npop, got;
    logic [NF-1:0] first_pe, second_pe, prev_pe;
    n_cmp = 0; n_err = 0; cyc = 0; run = 0;
    chk_en = 0; rand_push = 0;
    m_rr = 0; m_stat = 0; pops_left = 0; gv_prev = 0; pv_prev = 0;
    for (int f = 0; f < NF; f++) begin occ[f] = 0; m_age[f] = 0; end
    reset = 1; start = 0; number_of_flows = 2'd3; l_tx_batch_size = 2'd2;
    flush_timeout = '0; tx_almost_full = 0; grant_ready = 1;
    drive_occ();
    repeat (3) tick();
    reset = 0;
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_pop_en", 32'(pop_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stat", stat_flush_cnt, 0);
    check("rst_grant_flow", 32'(grant_flow), 0);
    check("rst_grant_count", 32'(grant_count), 0);
    check("rst_grant_flush", 32'(grant_flush), 0);
    chk_en = 1;
    repeat (2) tick();
    check("idle_without_start", 32'(busy), 0);

    // Two full flows served round-robin with a 7-cycle batch period.
    occ[1] = 4; occ[3] = 4; drive_occ();
    start = 1;
    first_cyc = -1; second_cyc = -1; first_pe = '0; second_pe = '0; prev_pe = '0; npop = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (s_pe === 4'b0010) npop++;
      if (s_pe != 0 && prev_pe == 0) begin
        if (first_cyc < 0) begin first_cyc = cyc; first_pe = s_pe; end
        else if (second_cyc < 0) begin second_cyc = cyc; second_pe = s_pe; end
      end
      prev_pe = s_pe;
    end
    check("rr_first_flow", 32'(first_pe), 32'h2);
    check("rr_second_flow", 32'(second_pe), 32'h8);
    check("batch_period", 32'(second_cyc - first_cyc), 7);
    check("flow1_pop_cycles", 32'(npop), 4);
    check("busy_in_arb", 32'(busy), 1);

    // Partial batch flushed after the timeout.
    number_of_flows = 2'd0; l_tx_batch_size = 2'd1; flush_timeout = 16'd10;
    occ[0] = 1; drive_occ();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flush_early", 32'(s_gv), 0);
    end
    got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      tick();
      if (s_gv === 1'b1) got = 1;
    end
    check("flush_grant_seen", 32'(got), 1);
    check("flush_flow", 32'(grant_flow), 0);
    check("flush_count", 32'(grant_count), 1);
    check("flush_flag", 32'(grant_flush), 1);
    repeat (4) tick();
    check("flush_stat", stat_flush_cnt, 1);

    // Zero timeout never flushes.
    flush_timeout = '0; occ[0] = 1; drive_occ();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_gv === 1'b1) got = 1;
    end
    check("no_flush_when_disabled", 32'(got), 0);
    occ[0] = 0; drive_occ();
    repeat (2) tick();

    // Almost-full gates new batches but never splits one in progress.
    l_tx_batch_size = 2'd2; tx_almost_full = 1; occ[0] = 4; drive_occ();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("af_blocks", 32'(s_gv), 0);
    end
    tx_almost_full = 0;
    got = 0;
    for (int i = 0; i < 3 && got == 0; i++) begin
      tick();
      if (s_gv === 1'b1) got = 1;
    end
    check("af_release_grant", 32'(got), 1);
    npop = 0;
    for (int i = 0; i < 4 && npop == 0; i++) begin
      tick();
      if (s_pe === 4'b0001) npop++;
    end
    tx_almost_full = 1;
    repeat (6) begin
      tick();
      if (s_pe === 4'b0001) npop++;
    end
    check("af_batch_unsplit", 32'(npop), 4);
    tx_almost_full = 0;

    // Grant held while grant_ready is low.
    grant_ready = 0; number_of_flows = 2'd1; occ[1] = 4; drive_occ();
    got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      tick();
      if (s_gv === 1'b1) got = 1;
    end
    check("stall_grant_seen", 32'(got), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(s_gv), 1);
      check("stall_flow", 32'(grant_flow), 1);
      check("stall_count", 32'(grant_count), 4);
      check("stall_no_pop", 32'(s_pe), 0);
    end
    grant_ready = 1;
    tick();
    tick();
    check("pop_after_ready", 32'(s_pe), 32'h2);
    repeat (5) tick();

    // Inactive flows are ignored; batch size 3 clamps to 4.
    l_tx_batch_size = 2'd3; occ[1] = 5; occ[3] = 8; drive_occ();
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      tick();
      if (s_gv === 1'b1) got = 1;
    end
    check("clamp_grant_seen", 32'(got), 1);
    check("clamp_flow", 32'(grant_flow), 1);
    check("clamp_count", 32'(grant_count), 4);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("no_flow3", 32'(s_gv === 1'b1 && grant_flow == 2'd3), 0);
    end
    occ[1] = 0; occ[3] = 0; drive_occ();
    l_tx_batch_size = 2'd2;
    repeat (2) tick();

    // Reset in the middle of a batch.
    occ[0] = 4; drive_occ();
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      tick();
      if (s_pe === 4'b0001) got = 1;
    end
    check("pre_reset_pop", 32'(got), 1);
    reset = 1;
    tick();
    reset = 0;
    check("rst_mid_pop_en", 32'(pop_en), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_valid", 32'(grant_valid), 0);
    check("rst_mid_stat", stat_flush_cnt, 0);
    occ[0] = 4; occ[1] = 4; drive_occ();
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      tick();
      if (s_gv === 1'b1) got = 1;
    end
    check("rr_after_reset_seen", 32'(got), 1);
    check("rr_after_reset_flow", 32'(grant_flow), 1);
    repeat (16) tick();

    // Random traffic against the model.
    rand_push = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        number_of_flows = 2'($urandom_range(0, 3));
        l_tx_batch_size = 2'($urandom_range(0, 3));
        flush_timeout   = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(2, 30));
      end
      tx_almost_full = ($urandom_range(0, 9) < 2);
      grant_ready    = ($urandom_range(0, 3) != 0);
      start          = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
